// File: rtl/pht_pkg.sv
// Shared FSM type and saturating-counter helpers for the pattern history table.
// Helpers take a wide counter plus the live width so any CNT_WIDTH up to MAX_CNT_W works.
package pht_pkg;

  localparam int MAX_CNT_W = 16;

  typedef enum logic {ST_INIT, ST_RUN} pht_state_t;
  typedef logic [MAX_CNT_W-1:0] cnt_t;

  function automatic cnt_t cnt_max(input int unsigned width);
    return (cnt_t'(1) << width) - cnt_t'(1);
  endfunction

  function automatic cnt_t sat_update(input cnt_t cnt, input logic taken,
                                      input int unsigned width);
    if (taken) return (cnt == cnt_max(width)) ? cnt : cnt + cnt_t'(1);
    return (cnt == '0) ? cnt : cnt - cnt_t'(1);
  endfunction

  function automatic logic is_saturated(input cnt_t cnt, input int unsigned width);
    return (cnt == '0) || (cnt == cnt_max(width));
  endfunction

endpackage

// File: rtl/pht_init_fsm.sv
// Init walk sequencer: one entry per cycle, RUN and ready_o after the last entry.
// Latency ENTRIES cycles from reset/flush; no backpressure, flush restarts the walk.
module pht_init_fsm
  import pht_pkg::*;
#(
  parameter int LOG_ENTRIES = 10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush_i,
  output logic                   ready_o,
  output logic                   run,
  output logic                   init_we,
  output logic [LOG_ENTRIES-1:0] init_idx
);

  pht_state_t             state;
  logic [LOG_ENTRIES-1:0] ptr;

  always_ff @(posedge clock) begin
    if (!reset_n || flush_i) begin
      state   <= ST_INIT;
      ptr     <= '0;
      ready_o <= 1'b0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + LOG_ENTRIES'(1);
      if (ptr == '1) begin
        state   <= ST_RUN;
        ready_o <= 1'b1;
      end
    end
  end

  assign run      = (state == ST_RUN);
  assign init_we  = (state == ST_INIT);
  assign init_idx = ptr;

endmodule

// File: rtl/pht_mp.sv
// Multi-read-port PHT: reads registered (1 cycle) with write bypass, updates as 2-stage RMW.
// One update per cycle, no backpressure; updates outside RUN are dropped.
module pht_mp
  import pht_pkg::*;
#(
  parameter int                   LOG_ENTRIES = 10,
  parameter int                   CNT_WIDTH   = 2,
  parameter logic [CNT_WIDTH-1:0] CNT_INIT    = 2'b10,
  parameter int                   NUM_RD      = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush_i,
  output logic                          ready_o,
  input  logic [NUM_RD-1:0]             rd_valid_i,
  input  logic [NUM_RD*LOG_ENTRIES-1:0] rd_index_i,
  output logic [NUM_RD-1:0]             rd_valid_o,
  output logic [NUM_RD-1:0]             rd_pred_o,
  output logic [NUM_RD-1:0]             rd_conf_o,
  input  logic                          upd_valid_i,
  input  logic [LOG_ENTRIES-1:0]        upd_index_i,
  input  logic                          upd_taken_i
);

  localparam int ENTRIES = 1 << LOG_ENTRIES;

  logic [CNT_WIDTH-1:0]   mem [ENTRIES];
  logic                   run;
  logic                   init_we;
  logic [LOG_ENTRIES-1:0] init_idx;

  logic                   u1_vld;
  logic [LOG_ENTRIES-1:0] u1_idx;
  logic                   u1_taken;
  logic [CNT_WIDTH-1:0]   upd_dat;
  logic                   upd_we;

  logic                   wr_en;
  logic [LOG_ENTRIES-1:0] wr_idx;
  logic [CNT_WIDTH-1:0]   wr_dat;
  logic [CNT_WIDTH-1:0]   rd_val [NUM_RD];

  pht_init_fsm #(
    .LOG_ENTRIES(LOG_ENTRIES)
  ) u_init (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .run      (run),
    .init_we  (init_we),
    .init_idx (init_idx)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) u1_vld <= 1'b0;
    else          u1_vld <= upd_valid_i & run & ~flush_i;
  end

  always_ff @(posedge clock) begin
    if (upd_valid_i) begin
      u1_idx   <= upd_index_i;
      u1_taken <= upd_taken_i;
    end
  end

  // Flush or reset in the write cycle kills the pending update.
  assign upd_dat = CNT_WIDTH'(sat_update(cnt_t'(mem[u1_idx]), u1_taken, CNT_WIDTH));
  assign upd_we  = u1_vld & run & ~flush_i & reset_n;
  assign wr_en   = upd_we | (init_we & reset_n);
  assign wr_idx  = upd_we ? u1_idx  : init_idx;
  assign wr_dat  = upd_we ? upd_dat : CNT_INIT;

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

  // While walking, every entry is (or is about to be) CNT_INIT, so reads return it directly.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val[p] = CNT_INIT;
      if (run) begin
        if (upd_we && (u1_idx == rd_index_i[p*LOG_ENTRIES +: LOG_ENTRIES]))
          rd_val[p] = upd_dat;
        else
          rd_val[p] = mem[rd_index_i[p*LOG_ENTRIES +: LOG_ENTRIES]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_valid_o <= '0;
      rd_pred_o  <= '0;
      rd_conf_o  <= '0;
    end else begin
      rd_valid_o <= rd_valid_i;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_valid_i[p]) begin
          rd_pred_o[p] <= rd_val[p][CNT_WIDTH-1];
          rd_conf_o[p] <= is_saturated(cnt_t'(rd_val[p]), CNT_WIDTH);
        end
      end
    end
  end

endmodule

// File: tb/tb_pht_mp.sv
// Bench for pht_mp: directed scenarios plus random traffic against a table-level reference model.
module tb_pht_mp;

  localparam int LOG_E = 4;
  localparam int CW    = 2;
  localparam int NRD   = 2;
  localparam int ENT   = 16;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int INITV = 2;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               flush_i;
  logic               ready_o;
  logic [NRD-1:0]     rd_valid_i;
  logic [NRD*LOG_E-1:0] rd_index_i;
  logic [NRD-1:0]     rd_valid_o;
  logic [NRD-1:0]     rd_pred_o;
  logic [NRD-1:0]     rd_conf_o;
  logic               upd_valid_i;
  logic [LOG_E-1:0]   upd_index_i;
  logic               upd_taken_i;

  int n_cmp = 0;
  int n_bad = 0;

  int cnt [ENT];
  int walk_left;
  bit pend_v;
  int pend_idx;
  bit pend_tk;
  bit m_ready;
  bit m_rv   [NRD];
  bit m_pred [NRD];
  bit m_conf [NRD];

  pht_mp #(
    .LOG_ENTRIES(LOG_E),
    .CNT_WIDTH  (CW),
    .CNT_INIT   (2'b10),
    .NUM_RD     (NRD)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .ready_o     (ready_o),
    .rd_valid_i  (rd_valid_i),
    .rd_index_i  (rd_index_i),
    .rd_valid_o  (rd_valid_o),
    .rd_pred_o   (rd_pred_o),
    .rd_conf_o   (rd_conf_o),
    .upd_valid_i (upd_valid_i),
    .upd_index_i (upd_index_i),
    .upd_taken_i (upd_taken_i)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  function automatic int bump(input int c, input bit tk);
    if (tk) return (c >= CMAX) ? CMAX : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  // Table semantics at one rising edge, using the inputs present at that edge.
  task automatic model_step();
    bit in_run;
    bit wr;
    int nv;
    int ri;
    int v;
    if (!reset_n) begin
      walk_left = ENT;
      pend_v    = 1'b0;
      m_ready   = 1'b0;
      for (int p = 0; p < NRD; p++) begin
        m_rv[p] = 1'b0; m_pred[p] = 1'b0; m_conf[p] = 1'b0;
      end
    end else begin
      in_run = (walk_left == 0);
      wr     = in_run && pend_v && !flush_i;
      nv     = bump(cnt[pend_idx], pend_tk);
      for (int p = 0; p < NRD; p++) begin
        m_rv[p] = rd_valid_i[p];
        if (rd_valid_i[p]) begin
          ri = int'(rd_index_i[p*LOG_E +: LOG_E]);
          if (!in_run)                 v = INITV;
          else if (wr && ri == pend_idx) v = nv;
          else                         v = cnt[ri];
          m_pred[p] = (v >= (CMAX + 1) / 2);
          m_conf[p] = (v == 0) || (v == CMAX);
        end
      end
      if (wr) cnt[pend_idx] = nv;
      pend_v   = upd_valid_i && in_run && !flush_i;
      pend_idx = int'(upd_index_i);
      pend_tk  = upd_taken_i;
      if (flush_i) walk_left = ENT;
      else if (walk_left > 0) begin
        walk_left--;
        if (walk_left == 0) foreach (cnt[i]) cnt[i] = INITV;
      end
      m_ready = (walk_left == 0);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clock);
    model_step();
    #1;
    chk({tag, ".ready"}, ready_o, m_ready);
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("%s.rv%0d", tag, p),   rd_valid_o[p], m_rv[p]);
      chk($sformatf("%s.pred%0d", tag, p), rd_pred_o[p],  m_pred[p]);
      chk($sformatf("%s.conf%0d", tag, p), rd_conf_o[p],  m_conf[p]);
    end
  endtask

  task automatic idle();
    rd_valid_i  = '0;
    upd_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic rd(input int p, input int idx);
    rd_valid_i[p] = 1'b1;
    rd_index_i[p*LOG_E +: LOG_E] = LOG_E'(idx);
  endtask

  task automatic upd(input int idx, input bit tk);
    upd_valid_i = 1'b1;
    upd_index_i = LOG_E'(idx);
    upd_taken_i = tk;
  endtask

  initial begin
    foreach (cnt[i]) cnt[i] = INITV;
    pend_idx = 0;
    reset_n = 1'b0;
    idle();
    rd_index_i  = '0;
    upd_index_i = '0;
    upd_taken_i = 1'b0;
    repeat (2) cyc("rst");

    // 1: walk latency, reads during and after the walk
    reset_n = 1'b1;
    for (int k = 0; k < ENT; k++) begin
      rd(0, k);
      cyc("s1w");
      if (k == ENT - 2) chk("s1.ready_low_c16", ready_o, 1'b0);
    end
    chk("s1.ready_c17", ready_o, 1'b1);
    for (int k = 0; k < ENT; k++) begin
      rd(0, k);
      cyc("s1r");
      chk("s1.pred", rd_pred_o[0], 1'b1);
      chk("s1.conf", rd_conf_o[0], 1'b0);
    end

    // 2: not-taken saturates at zero
    idle();
    repeat (3) begin upd(5, 1'b0); cyc("s2u"); end
    idle(); cyc("s2i");
    rd(0, 5); cyc("s2r");
    chk("s2.pred", rd_pred_o[0], 1'b0);
    chk("s2.conf", rd_conf_o[0], 1'b1);

    // 3: taken saturates at max, read on port 1
    idle();
    repeat (3) begin upd(9, 1'b1); cyc("s3u"); end
    idle(); cyc("s3i");
    rd(1, 9); cyc("s3r");
    chk("s3.pred", rd_pred_o[1], 1'b1);
    chk("s3.conf", rd_conf_o[1], 1'b1);

    // 4: bypass on both ports, then an unrelated index alongside
    idle(); upd(5, 1'b1); cyc("s4u");
    idle(); rd(0, 5); rd(1, 5); cyc("s4b");
    chk("s4.pred0", rd_pred_o[0], 1'b0);
    chk("s4.conf0", rd_conf_o[0], 1'b0);
    chk("s4.pred1", rd_pred_o[1], 1'b0);
    chk("s4.conf1", rd_conf_o[1], 1'b0);
    idle(); upd(5, 1'b1); cyc("s4u2");
    idle(); rd(0, 5); rd(1, 6); cyc("s4c");
    chk("s4.idx6_pred", rd_pred_o[1], 1'b1);
    chk("s4.idx6_conf", rd_conf_o[1], 1'b0);

    // 5: back-to-back taken from 01
    idle(); upd(3, 1'b0); cyc("s5d");
    idle(); cyc("s5i");
    upd(3, 1'b1); cyc("s5t0");
    upd(3, 1'b1); cyc("s5t1");
    idle(); cyc("s5i2");
    rd(0, 3); cyc("s5r");
    chk("s5.pred", rd_pred_o[0], 1'b1);
    chk("s5.conf", rd_conf_o[0], 1'b1);

    // 6: flush cancels the pending write; updates during the walk are ignored
    idle(); upd(2, 1'b1); cyc("s6u");
    idle(); flush_i = 1'b1; cyc("s6f");
    chk("s6.ready_fall", ready_o, 1'b0);
    flush_i = 1'b0;
    for (int k = 0; k < ENT; k++) begin
      upd(k % 4, 1'b1);
      rd(0, 2);
      cyc("s6w");
      if (k < ENT - 1) chk("s6.ready_low", ready_o, 1'b0);
    end
    chk("s6.ready_back", ready_o, 1'b1);
    idle(); rd(0, 2); rd(1, 0); cyc("s6r");
    chk("s6.idx2_pred", rd_pred_o[0], 1'b1);
    chk("s6.idx2_conf", rd_conf_o[0], 1'b0);
    chk("s6.idx0_conf", rd_conf_o[1], 1'b0);

    // random traffic over a narrow index range to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      reset_n     = ($urandom_range(0, 299) != 0);
      flush_i     = ($urandom_range(0, 79) == 0);
      upd_valid_i = 1'($urandom_range(0, 1));
      upd_index_i = LOG_E'($urandom_range(0, 5));
      upd_taken_i = 1'($urandom_range(0, 1));
      for (int p = 0; p < NRD; p++) begin
        rd_valid_i[p] = 1'($urandom_range(0, 1));
        rd_index_i[p*LOG_E +: LOG_E] =
          ($urandom_range(0, 7) == 0) ? LOG_E'($urandom_range(0, ENT - 1))
                                      : LOG_E'($urandom_range(0, 5));
      end
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
